// File: rtl/jstk_spi_master_if.sv
// PmodJSTK pin and result bundle.
// The master side drives SPI and results; the slave side is the joystick/consumer.
interface jstk_spi_master_if;
  logic [1:0] led;
  logic       miso;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic [9:0] xdata;
  logic [9:0] ydata;
  logic [2:0] btn;
  logic       dav;

  modport master (
    input  led, miso,
    output ss, sclk, mosi,
    output xdata, ydata, btn, dav
  );

  modport slave (
    output led, miso,
    input  ss, sclk, mosi,
    input  xdata, ydata, btn, dav
  );
endinterface

// File: rtl/jstk_spi_master.sv
// Mode-0 SPI master that polls a PmodJSTK and
// presents X/Y/buttons with a one-clock valid pulse.
module jstk_spi_master #(
  parameter int CLKDIV     = 50,
  parameter int SSDELAY    = 750,
  parameter int BYTEGAP    = 500,
  parameter int POLLPERIOD = 500000
) (
  input  logic             clock,
  input  logic             reset,
  jstk_spi_master_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SSLOW = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_DAV   = 3'd5;

  localparam logic [15:0] DIV_L  = 16'(CLKDIV - 1);
  localparam logic [15:0] SSD_L  = 16'(SSDELAY - 1);
  localparam logic [15:0] GAP_L  = 16'(BYTEGAP - 1);
  localparam logic [19:0] POLL_L = 20'(POLLPERIOD - 1);

  logic [2:0]  state;
  logic [19:0] timer;
  logic        pend;
  logic [15:0] cnt;
  logic        sclk;
  logic        ss;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic [2:0]  bitcnt;
  logic [2:0]  idx;
  logic [7:0]  b0;
  logic [1:0]  b1;
  logic [7:0]  b2;
  logic [1:0]  b3;
  logic [2:0]  b4;
  logic [9:0]  xdata;
  logic [9:0]  ydata;
  logic [2:0]  btn;
  logic        dav;

  logic wrap;
  logic start;

  assign wrap  = (timer == POLL_L);
  // A wrap missed while busy is remembered and served on return to idle.
  assign start = (state == S_IDLE) && (wrap || pend);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      timer  <= '0;
      pend   <= 1'b0;
      cnt    <= '0;
      sclk   <= 1'b0;
      ss     <= 1'b1;
      tx     <= '0;
      rx     <= '0;
      bitcnt <= '0;
      idx    <= '0;
      b0     <= '0;
      b1     <= '0;
      b2     <= '0;
      b3     <= '0;
      b4     <= '0;
      xdata  <= '0;
      ydata  <= '0;
      btn    <= '0;
      dav    <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + 20'd1;
      dav   <= 1'b0;
      if (start)
        pend <= 1'b0;
      else if (wrap)
        pend <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            tx     <= {6'b100000, bus.led};
            idx    <= '0;
            bitcnt <= '0;
            cnt    <= '0;
            ss     <= 1'b0;
            state  <= S_SSLOW;
          end
        end
        S_SSLOW: begin
          if (cnt == SSD_L) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (cnt != DIV_L) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              rx   <= {rx[6:0], bus.miso};
            end else begin
              sclk <= 1'b0;
              if (bitcnt == 3'd7) begin
                unique case (idx)
                  3'd0:    b0 <= rx;
                  3'd1:    b1 <= rx[1:0];
                  3'd2:    b2 <= rx;
                  3'd3:    b3 <= rx[1:0];
                  default: b4 <= rx[2:0];
                endcase
                tx     <= '0;
                bitcnt <= '0;
                state  <= (idx == 3'd4) ? S_DONE : S_GAP;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                bitcnt <= bitcnt + 3'd1;
              end
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_L) begin
            cnt   <= '0;
            idx   <= idx + 3'd1;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          ss    <= 1'b1;
          xdata <= {b1, b0};
          ydata <= {b3, b2};
          btn   <= b4;
          state <= S_DAV;
        end
        S_DAV: begin
          dav   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ss    = ss;
  assign bus.sclk  = sclk;
  assign bus.mosi  = tx[7];
  assign bus.xdata = xdata;
  assign bus.ydata = ydata;
  assign bus.btn   = btn;
  assign bus.dav   = dav;

endmodule
